previn_cmd_rx: RTL and testbench
================================

PREVIN_CMD_RX -- requirements
Module: previn_cmd_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per UART bit (minimum 4).
REQ-002 SHALL have parameter TRIG_LEN, default 4, previn_trig high time in clocks (1 .. 10*CLKS_PER_BIT-1).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096, maximum idle clocks between bytes of one packet.
REQ-004 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port uart_rx  input  1  PC serial line, asynchronous, idle high, 8N1, LSB first.
REQ-007 SHALL have port previn_code  output  8  last accepted PREVIN code, registered.
REQ-008 SHALL have port previn_trig  output  1  load strobe for the downstream PREVIN shifter, registered.
REQ-009 SHALL have port pkt_cnt  output  8  accepted-packet counter, wraps 255->0.
REQ-010 SHALL have port frame_err  output  1  one-clock pulse on a bad stop bit.
REQ-011 SHALL have port pkt_err  output  1  one-clock pulse on bad header-phase command, bad checksum or timeout.

Function
REQ-012 SHALL pass uart_rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-013 SHALL implement RX FSM states IDLE, START, DATA, STOP with a bit-timer counter and a 3-bit bit index.
REQ-014 IDLE->START on a synchronized falling edge; START re-checks the line at CLKS_PER_BIT/2 and returns to IDLE if it is high (glitch reject).
REQ-015 DATA SHALL sample each of 8 bits at mid-bit (CLKS_PER_BIT after the previous sample), shifting LSB first.
REQ-016 STOP SHALL sample at mid-bit: 1 -> byte_valid pulse with the byte; 0 -> frame_err pulse, byte discarded, parser forced to P_HDR.
REQ-017 RX FSM SHALL return to IDLE at the stop-bit sample, so back-to-back frames with one stop bit are received.
REQ-018 SHALL implement parser states P_HDR, P_CMD, P_CODE, P_SUM, advancing on byte_valid only.
REQ-019 P_HDR SHALL accept only 0xA5; other bytes are silently dropped, state unchanged.
REQ-020 P_CMD SHALL accept only 0x50; any other byte -> pkt_err pulse, go to P_HDR.
REQ-021 P_CODE SHALL store the byte as pending code.
REQ-022 P_SUM SHALL compare the byte to (0x50 + pending code) mod 256; mismatch -> pkt_err pulse, previn_code unchanged, go to P_HDR.
REQ-023 On checksum match: previn_code <= pending code at clock N, previn_trig rises at N+1 and stays high exactly TRIG_LEN clocks, pkt_cnt increments at N, parser goes to P_HDR.
REQ-024 previn_code SHALL never change while previn_trig is high.
REQ-025 In P_CMD/P_CODE/P_SUM an idle counter SHALL count clocks since the last byte_valid; reaching TIMEOUT_CYC -> pkt_err pulse, go to P_HDR; the counter is held at 0 in P_HDR.
REQ-026 frame_err and a parser error in the same clock SHALL both pulse; parser goes to P_HDR.

Reset
REQ-027 rst_n low SHALL asynchronously force: RX FSM IDLE, parser P_HDR, synchronizer 1, previn_code 0x00, previn_trig 0, pkt_cnt 0, frame_err 0, pkt_err 0, all counters 0.
REQ-028 Reset asserted mid-frame or mid-trig-pulse SHALL abort it; after release the first start bit is that of a fresh frame, and no trig is emitted for the aborted packet.

Verification
REQ-029 Bytes A5 50 3C 8C (CLKS_PER_BIT=16) -> previn_code=0x3C one clock after the last stop sample, previn_trig high 4 clocks starting the next clock, pkt_cnt=1.
REQ-030 Bytes A5 50 3C 8D -> one pkt_err pulse, previn_code and pkt_cnt unchanged, trig stays low; following A5 50 01 51 is accepted (code 0x01).
REQ-031 Frame with stop bit 0 in the CODE byte -> one frame_err pulse, no trig; a full valid packet afterwards is accepted.
REQ-032 A5 50 then 5000 idle clocks -> pkt_err at clock 4096 after the 0x50 stop sample; later 3C 8C alone produces no trig.
REQ-033 2-clock low glitch on uart_rx in IDLE -> no byte_valid, no error pulses; 256 valid packets -> pkt_cnt wraps to 0.
REQ-034 rst_n pulsed low during the DATA bits of the SUM byte -> all outputs at reset values, no trig; next valid packet accepted.

Source files
------------

// File: rtl/previn_cmd_rx.sv
// previn_cmd_rx: 8N1 UART receiver plus a 4-byte command parser
// (A5 50 code sum). An accepted code is latched onto previn_code and
// announced with a fixed-width previn_trig strobe one clock later.
module previn_cmd_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TRIG_LEN     = 4,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] previn_code,
  output logic       previn_trig,
  output logic [7:0] pkt_cnt,
  output logic       frame_err,
  output logic       pkt_err
);

  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int TLW = $clog2(TRIG_LEN + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {P_HDR, P_CMD, P_CODE, P_SUM} p_state_t;

  rx_state_t      rx_state_q, rx_state_d;
  logic           sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           byte_vld_q, byte_vld_d;
  logic           frame_err_q, frame_err_d;

  p_state_t       p_state_q, p_state_d;
  logic [7:0]     pend_q, pend_d;
  logic [7:0]     code_q, code_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           pkt_err_q, pkt_err_d;
  logic           trig_start_q, trig_start_d;
  logic           trig_q, trig_d;
  logic [TLW-1:0] trig_cnt_q, trig_cnt_d;
  logic [TW-1:0]  idle_cnt_q, idle_cnt_d;
  logic           timeout;
  logic [7:0]     sum_exp;

  // RX: synchronizer, start-edge detect, mid-bit sampling of 8N1 frames.
  // A falling edge (not a low level) is required to start, so a frame
  // that ends on a bad (low) stop bit cannot immediately re-trigger.
  always_comb begin
    sync1_d     = uart_rx;
    sync2_d     = sync1_q;
    rx_prev_d   = sync2_q;
    rx_state_d  = rx_state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      IDLE: if (rx_prev_q && !sync2_q) begin
        rx_state_d = START;
        bit_cnt_d  = '0;
      end
      START: if (bit_cnt_q == BW'(CLKS_PER_BIT / 2 - 1)) begin
        bit_cnt_d  = '0;
        bit_idx_d  = '0;
        rx_state_d = sync2_q ? IDLE : DATA;
      end else bit_cnt_d = bit_cnt_q + 1'b1;
      DATA: if (bit_cnt_q == BW'(CLKS_PER_BIT - 1)) begin
        bit_cnt_d = '0;
        shreg_d   = {sync2_q, shreg_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) rx_state_d = STOP;
      end else bit_cnt_d = bit_cnt_q + 1'b1;
      STOP: if (bit_cnt_q == BW'(CLKS_PER_BIT - 1)) begin
        bit_cnt_d   = '0;
        rx_state_d  = IDLE;
        byte_vld_d  = sync2_q;
        frame_err_d = !sync2_q;
      end else bit_cnt_d = bit_cnt_q + 1'b1;
      default: rx_state_d = IDLE;
    endcase
  end

  // RX state register; line side resets to idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign sum_exp = 8'h50 + pend_q;

  // Parser, inter-byte timeout and trig pulse generation. shreg_q is stable
  // while byte_vld_q is high because the RX only shifts in DATA.
  always_comb begin
    p_state_d    = p_state_q;
    pend_d       = pend_q;
    code_d       = code_q;
    cnt_d        = cnt_q;
    pkt_err_d    = 1'b0;
    trig_start_d = 1'b0;
    trig_d       = trig_q;
    trig_cnt_d   = trig_cnt_q;
    idle_cnt_d   = '0;
    timeout      = 1'b0;
    if (p_state_q != P_HDR) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
      timeout    = (idle_cnt_d == TW'(TIMEOUT_CYC));
    end
    if (byte_vld_q) begin
      idle_cnt_d = '0;
      case (p_state_q)
        P_HDR:  if (shreg_q == 8'hA5) p_state_d = P_CMD;
        P_CMD:  if (shreg_q == 8'h50) p_state_d = P_CODE;
                else begin
                  pkt_err_d = 1'b1;
                  p_state_d = P_HDR;
                end
        P_CODE: begin
          pend_d    = shreg_q;
          p_state_d = P_SUM;
        end
        P_SUM: begin
          p_state_d = P_HDR;
          if (shreg_q == sum_exp) begin
            code_d       = pend_q;
            cnt_d        = cnt_q + 8'd1;
            trig_start_d = 1'b1;
          end else pkt_err_d = 1'b1;
        end
        default: p_state_d = P_HDR;
      endcase
    end else if (timeout) begin
      pkt_err_d  = 1'b1;
      p_state_d  = P_HDR;
      idle_cnt_d = '0;
    end
    // A bad stop bit always restarts header hunting.
    if (frame_err_q) begin
      p_state_d  = P_HDR;
      idle_cnt_d = '0;
    end
    if (trig_start_q) begin
      trig_d     = 1'b1;
      trig_cnt_d = TLW'(TRIG_LEN - 1);
    end else if (trig_q) begin
      if (trig_cnt_q == '0) trig_d = 1'b0;
      else trig_cnt_d = trig_cnt_q - 1'b1;
    end
  end

  // Parser / output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state_q    <= P_HDR;
      pend_q       <= '0;
      code_q       <= '0;
      cnt_q        <= '0;
      pkt_err_q    <= 1'b0;
      trig_start_q <= 1'b0;
      trig_q       <= 1'b0;
      trig_cnt_q   <= '0;
      idle_cnt_q   <= '0;
    end else begin
      p_state_q    <= p_state_d;
      pend_q       <= pend_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
      pkt_err_q    <= pkt_err_d;
      trig_start_q <= trig_start_d;
      trig_q       <= trig_d;
      trig_cnt_q   <= trig_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  assign previn_code = code_q;
  assign previn_trig = trig_q;
  assign pkt_cnt     = cnt_q;
  assign frame_err   = frame_err_q;
  assign pkt_err     = pkt_err_q;

endmodule

// File: tb/tb_previn_cmd_rx.sv
// Bench for previn_cmd_rx: directed scenarios plus randomized packets,
// checked against a byte-queue packet model.
module tb_previn_cmd_rx;
  localparam int CPB = 4;
  localparam int TL  = 4;
  localparam int TO  = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] previn_code, pkt_cnt;
  logic       previn_trig, frame_err, pkt_err;

  always #5 clk = ~clk;

  previn_cmd_rx #(.CLKS_PER_BIT(CPB), .TRIG_LEN(TL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .previn_code(previn_code), .previn_trig(previn_trig), .pkt_cnt(pkt_cnt),
    .frame_err(frame_err), .pkt_err(pkt_err)
  );

  int n_tests = 0, n_fail = 0;

  // observation records
  int cyc = 0;
  int perr_n = 0, ferr_n = 0, trig_n = 0, badlen_n = 0, moved_n = 0;
  int perr_cyc = 0, code_chg_cyc = 0, rise_cyc = 0, last_tlen = 0, tlen = 0;
  logic [7:0] code_prev = 8'h00;
  logic trig_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // record pulses, trig widths and code movement, sampled mid-cycle
  always @(negedge clk) begin
    if (pkt_err) begin perr_n <= perr_n + 1; perr_cyc <= cyc; end
    if (frame_err) ferr_n <= ferr_n + 1;
    if (previn_code !== code_prev) begin
      code_chg_cyc <= cyc;
      if (previn_trig) moved_n <= moved_n + 1;
    end
    code_prev <= previn_code;
    if (previn_trig && !trig_prev) begin
      trig_n <= trig_n + 1; rise_cyc <= cyc; tlen <= 1;
    end else if (previn_trig) tlen <= tlen + 1;
    if (!previn_trig && trig_prev) begin
      last_tlen <= tlen;
      if (tlen != TL) badlen_n <= badlen_n + 1;
    end
    trig_prev <= previn_trig;
  end

  // packet model: bytes collected since a header
  logic [7:0] pq[$];
  logic [7:0] exp_code = 8'h00, exp_cnt = 8'h00;
  int exp_perr = 0, exp_ferr = 0, exp_trig = 0;
  int t_stop = 0;

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_ferr++; pq.delete();
    end else if (pq.size() == 0) begin
      if (b == 8'hA5) pq.push_back(b);
    end else begin
      pq.push_back(b);
      if (pq.size() == 2 && b != 8'h50) begin
        exp_perr++; pq.delete();
      end else if (pq.size() == 4) begin
        if (b == 8'(pq[2] + 8'h50)) begin
          exp_code = pq[2]; exp_cnt = exp_cnt + 8'd1; exp_trig++;
        end else exp_perr++;
        pq.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    n_tests++;
    assert (v >= lo && v <= hi) else begin
      n_fail++; $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_bit, input int gap);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i == 9) t_stop = cyc;
      uart_rx = fr[i];
      repeat (CPB) @(posedge clk);
    end
    #1 uart_rx = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic xfer(input logic [7:0] b, input bit ok, input int gap);
    send_byte(b, ok, gap);
    model_byte(b, ok);
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] s);
    xfer(8'hA5, 1'b1, 1); xfer(8'h50, 1'b1, 0);
    xfer(c, 1'b1, 2);     xfer(s, 1'b1, 0);
  endtask

  task automatic settle();
    repeat (TL + 12) @(posedge clk);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".code"}, previn_code, exp_code);
    chk({tag, ".cnt"}, pkt_cnt, exp_cnt);
    chk({tag, ".perr"}, perr_n, exp_perr);
    chk({tag, ".ferr"}, ferr_n, exp_ferr);
    chk({tag, ".trigs"}, trig_n, exp_trig);
    chk({tag, ".badlen"}, badlen_n, 0);
    chk({tag, ".moved"}, moved_n, 0);
  endtask

  logic [7:0] bq[$];
  bit         oq[$];
  logic [7:0] c, s, j;
  int         t0, kind;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.code", previn_code, 8'h00);
    chk("rst.trig", previn_trig, 1'b0);
    chk("rst.cnt", pkt_cnt, 8'h00);
    chk("rst.ferr", frame_err, 1'b0);
    chk("rst.perr", pkt_err, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // basic packet: code latched, trig one clock later for TL clocks
    send_pkt(8'h3C, 8'h8C);
    settle();
    check_all("basic");
    chk_rng("basic.code_lat", code_chg_cyc - t_stop, CPB / 2, CPB / 2 + 6);
    chk("basic.rise_gap", rise_cyc - code_chg_cyc, 1);
    chk("basic.tlen", last_tlen, TL);

    // bad checksum then a good packet
    send_pkt(8'h3C, 8'h8D);
    settle();
    check_all("badsum");
    send_pkt(8'h01, 8'h51);
    settle();
    check_all("after_badsum");
    chk("after_badsum.rise_gap", rise_cyc - code_chg_cyc, 1);

    // bad stop bit in the code byte, then a good packet
    xfer(8'hA5, 1'b1, 1); xfer(8'h50, 1'b1, 1); xfer(8'h3C, 1'b0, 3);
    settle();
    check_all("frame");
    send_pkt(8'h77, 8'hC7);
    settle();
    check_all("after_frame");

    // inter-byte timeout; orphan code/sum bytes afterwards are dropped
    xfer(8'hA5, 1'b1, 1); xfer(8'h50, 1'b1, 0);
    t0 = t_stop;
    repeat (5000) @(posedge clk);
    exp_perr++; pq.delete();
    check_all("timeout");
    chk_rng("timeout.when", perr_cyc - t0, TO + CPB / 2, TO + CPB / 2 + 6);
    xfer(8'h3C, 1'b1, 2); xfer(8'h8C, 1'b1, 2);
    settle();
    check_all("orphan");

    // a 2-clock glitch while waiting for the command byte must not be a byte
    xfer(8'hA5, 1'b1, 4);
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    xfer(8'h50, 1'b1, 0); xfer(8'h12, 1'b1, 0); xfer(8'h62, 1'b1, 0);
    settle();
    check_all("glitch");

    // randomized packets with assorted corruptions
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 4);
      c = 8'($urandom);
      s = c + 8'h50;
      bq.delete(); oq.delete();
      if (kind == 3) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h5A;
        bq.push_back(j); oq.push_back(1'b1);
      end
      if (kind == 1) s = s + 8'($urandom_range(1, 255));
      j = 8'h50;
      if (kind == 2) begin
        j = 8'($urandom);
        if (j == 8'h50) j = 8'h51;
      end
      bq.push_back(8'hA5); bq.push_back(j); bq.push_back(c); bq.push_back(s);
      repeat (4) oq.push_back(1'b1);
      if (kind == 4) oq[$urandom_range(0, 3)] = 1'b0;
      foreach (bq[k]) xfer(bq[k], oq[k], $urandom_range(0, 6));
      settle();
      check_all($sformatf("rand%0d", i));
    end

    // reset in the middle of the sum byte aborts the packet
    xfer(8'hA5, 1'b1, 1); xfer(8'h50, 1'b1, 1); xfer(8'h44, 1'b1, 1);
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1 uart_rx = 1'b0;
    repeat (2 * CPB) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.code", previn_code, 8'h00);
    chk("midrst.trig", previn_trig, 1'b0);
    chk("midrst.cnt", pkt_cnt, 8'h00);
    chk("midrst.ferr", frame_err, 1'b0);
    chk("midrst.perr", pkt_err, 1'b0);
    uart_rx = 1'b1;
    pq.delete(); exp_code = 8'h00; exp_cnt = 8'h00;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12 * CPB) @(posedge clk);
    check_all("midrst.after");

    // 256 good packets: counter wraps back to zero
    for (int i = 0; i < 256; i++) begin
      c = 8'($urandom);
      send_pkt(c, c + 8'h50);
    end
    settle();
    check_all("wrap");
    chk("wrap.zero", pkt_cnt, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
